// File: rtl/uart_sample_packer.sv
// Buffers 16-bit samples in a small FIFO and streams each one to uart_tx as a framed byte sequence.
// Optional checksum byte appended to each frame when PACKER_CHECKSUM_EN is defined.
module uart_sample_packer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_ni,
    input  logic [15:0]                   sample_i,
    input  logic                          sample_valid_i,
    input  logic                          tx_ready_i,
    output logic                          tx_send_o,
    output logic [7:0]                    tx_data_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

`ifdef PACKER_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GUARD,
        WAIT
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      idx_reg, idx_next;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]   level_reg, level_next;
    logic [15:0]     hold_reg;
    logic            send_reg;
    logic [7:0]      data_reg;
    logic            ovf_reg;
    logic [7:0]      byte_sel;

    logic full, empty, pop, push, drop;

    assign full  = (level_reg == DEPTH_L);
    assign empty = (level_reg == '0);
    assign pop   = (state_reg == LOAD);
    // A full FIFO still takes a sample when the same edge frees a slot.
    assign push  = sample_valid_i && (!full || pop);
    assign drop  = sample_valid_i && full && !pop;

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + LW'(1);
        end else if (!push && pop) begin
            level_next = level_reg - LW'(1);
        end
    end

    // Sample storage carries no reset so it maps onto RAM; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= sample_i;
        end
    end

    always_comb begin
        byte_sel = SYNC_BYTE;
        case (idx_reg)
            2'd1:    byte_sel = hold_reg[15:8];
            2'd2:    byte_sel = hold_reg[7:0];
`ifdef PACKER_CHECKSUM_EN
            2'd3:    byte_sel = SYNC_BYTE ^ hold_reg[15:8] ^ hold_reg[7:0];
`endif
            default: byte_sel = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (!empty && tx_ready_i) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                idx_next   = 2'd0;
                state_next = SEND;
            end
            SEND: begin
                state_next = GUARD;
            end
            // uart_tx needs a cycle to drop ready after seeing send, so ready is not trusted here.
            GUARD: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_ready_i) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx_reg + 2'd1;
                        state_next = SEND;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            idx_reg    <= 2'd0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            hold_reg   <= 16'h0000;
            send_reg   <= 1'b0;
            data_reg   <= 8'h00;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            level_reg <= level_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                hold_reg   <= mem[rd_ptr_reg];
            end
            send_reg <= (state_reg == SEND);
            if (state_reg == SEND) begin
                data_reg <= byte_sel;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign tx_send_o    = send_reg;
    assign tx_data_o    = data_reg;
    assign busy_o       = (state_reg != IDLE);
    assign overflow_o   = ovf_reg;
    assign fifo_level_o = level_reg;

    a_send_gap: assert property (@(posedge clk) disable iff (!rst_ni) send_reg |=> !send_reg);
    a_level_max: assert property (@(posedge clk) disable iff (!rst_ni) level_reg <= DEPTH_L);

endmodule

// File: tb/tb_uart_sample_packer.sv
// Directed bench for uart_sample_packer: a byte-stream model plus a uart_tx ready model.
// Frame length follows PACKER_CHECKSUM_EN.
module tb_uart_sample_packer;

    localparam int DEPTH     = 4;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int BYTE_TIME = 12;
`ifdef PACKER_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [15:0]   sample_i;
    logic          sample_valid_i;
    logic          tx_ready_i;
    logic          tx_send_o;
    logic [7:0]    tx_data_o;
    logic          busy_o;
    logic          overflow_o;
    logic [LW-1:0] fifo_level_o;

    always #5 clk = ~clk;

    uart_sample_packer #(
        .FIFO_DEPTH(DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk           (clk),
        .rst_ni        (rst_ni),
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .tx_ready_i    (tx_ready_i),
        .tx_send_o     (tx_send_o),
        .tx_data_o     (tx_data_o),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o),
        .fifo_level_o  (fifo_level_o)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_bytes [$];
    logic       exp_ovf   = 1'b0;
    logic       hold_low  = 1'b0;
    logic       cmp_en    = 1'b0;
    logic       prev_send = 1'b0;
    int         uart_cnt  = 0;
    logic       saw_send  = 1'b0;
    logic [7:0] cmp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected wire bytes for one accepted sample.
    task automatic add_frame(input logic [15:0] s);
        logic [7:0] hi, lo;
        hi = 8'((s >> 8) & 16'h00FF);
        lo = 8'(s & 16'h00FF);
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(hi);
        exp_bytes.push_back(lo);
`ifdef PACKER_CHECKSUM_EN
        exp_bytes.push_back(8'hA5 ^ hi ^ lo);
`endif
    endtask

    task automatic push_one(input logic [15:0] d, input bit acc);
        @(posedge clk); #1;
        sample_i       = d;
        sample_valid_i = 1'b1;
        if (acc) add_frame(d);
        @(posedge clk); #1;
        sample_valid_i = 1'b0;
        if (!acc) exp_ovf = 1'b1;
    endtask

    task automatic wait_send(input string name, output logic [7:0] d);
        bit found;
        found = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx_send_o) begin
                found = 1'b1;
                d = tx_data_o;
            end
        end
        chk(name, found, 1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy_o && fifo_level_o == '0 && exp_bytes.size() == 0) done = 1'b1;
        end
        chk(name, done, 1);
    endtask

    task automatic wait_ready_rise(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (tx_ready_i) seen = 1'b1;
        end
        chk(name, seen, 1);
    endtask

    // uart_tx stand-in: ready drops the edge after it takes send and stays low BYTE_TIME cycles.
    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (uart_cnt > 0) uart_cnt--;
            if (saw_send) uart_cnt = BYTE_TIME;
            saw_send   = tx_send_o;
            tx_ready_i = (uart_cnt == 0) && !hold_low;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("overflow", overflow_o, exp_ovf);
                chk("level_bound", fifo_level_o <= LW'(DEPTH), 1);
                if (tx_send_o) begin
                    chk("send_with_ready", tx_ready_i, 1);
                    chk("send_gap", prev_send, 0);
                    if (exp_bytes.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_send: got byte %0h, required no send", tx_data_o);
                    end else begin
                        cmp_b = exp_bytes.pop_front();
                        chk("tx_data", tx_data_o, cmp_b);
                    end
                end
                prev_send = tx_send_o;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         ns;
        rst_ni         = 1'b0;
        sample_i       = 16'h0000;
        sample_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_send", tx_send_o, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_level", fifo_level_o, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        cmp_en = 1'b1;

        // Single sample, idle uart: latency, literal bytes, busy returning low.
        push_one(16'h1234, 1'b1);
        @(negedge clk);
        chk("lat_c0_send", tx_send_o, 0);
        chk("lat_c0_level", fifo_level_o, 1);
        chk("lat_c0_busy", busy_o, 0);
        @(negedge clk);
        chk("lat_c1_send", tx_send_o, 0);
        chk("lat_c1_busy", busy_o, 1);
        @(negedge clk);
        chk("lat_c2_send", tx_send_o, 0);
        chk("lat_c2_level", fifo_level_o, 0);
        @(negedge clk);
        chk("lat_c3_send", tx_send_o, 1);
        chk("byte0_sync", tx_data_o, 8'hA5);
        wait_send("byte1_seen", d);
        chk("byte1_hi", d, 8'h12);
        wait_send("byte2_seen", d);
        chk("byte2_lo", d, 8'h34);
`ifdef PACKER_CHECKSUM_EN
        wait_send("byte3_seen", d);
        chk("byte3_cks", d, 8'h83);
`endif
        wait_drain("drain_single", 200);
        chk("busy_end", busy_o, 0);

        // Push landing on the LOAD pop with a full FIFO.
        push_one(16'hAAAA, 1'b1);
        wait_send("full_f0_byte0", d);
        push_one(16'h1111, 1'b1);
        push_one(16'h2222, 1'b1);
        push_one(16'h3333, 1'b1);
        push_one(16'h4444, 1'b1);
        @(negedge clk);
        chk("full_level4", fifo_level_o, 4);
        for (int k = 1; k < FRAME_LEN; k++) wait_send("full_f0_rest", d);
        hold_low = 1'b1;
        repeat (BYTE_TIME + 4) @(negedge clk);
        hold_low = 1'b0;
        wait_ready_rise("full_ready_rise");
        chk("full_busy_wait", busy_o, 1);
        @(negedge clk);
        chk("full_busy_idle", busy_o, 0);
        chk("full_level_idle", fifo_level_o, 4);
        push_one(16'h5555, 1'b1);
        @(negedge clk);
        chk("full_level_after_load", fifo_level_o, 4);
        chk("full_no_ovf", overflow_o, 0);
        wait_drain("drain_full", 1500);

        // Overflow while the first frame is busy.
        push_one(16'hBEEF, 1'b1);
        wait_send("ovf_f0_byte0", d);
        push_one(16'h0001, 1'b1);
        push_one(16'h0002, 1'b1);
        push_one(16'h0003, 1'b1);
        push_one(16'h0004, 1'b1);
        push_one(16'h0005, 1'b0);
        @(negedge clk);
        chk("ovf_level4", fifo_level_o, 4);
        chk("ovf_flag", overflow_o, 1);
        wait_drain("drain_ovf", 1500);
        chk("ovf_sticky", overflow_o, 1);

        // Ready held low in WAIT for 1000 cycles.
        push_one(16'h0F0F, 1'b1);
        wait_send("hold_byte0", d);
        hold_low = 1'b1;
        ns = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_send_o) ns++;
        end
        chk("hold_no_send", ns, 0);
        chk("hold_busy", busy_o, 1);
        hold_low = 1'b0;
        wait_ready_rise("hold_ready_rise");
        chk("rise_c0_send", tx_send_o, 0);
        @(negedge clk);
        chk("rise_c1_send", tx_send_o, 0);
        @(negedge clk);
        chk("rise_c2_send", tx_send_o, 1);
        chk("rise_c2_data", tx_data_o, 8'h0F);
        wait_drain("drain_hold", 300);

        // Reset after byte 1 of a frame, with one more sample queued.
        push_one(16'h5A12, 1'b1);
        wait_send("rst_f_byte0", d);
        push_one(16'h7777, 1'b1);
        wait_send("rst_f_byte1", d);
        chk("rst_f_byte1_val", d, 8'h5A);
        chk("rst_pre_level", fifo_level_o, 1);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        exp_ovf = 1'b0;
        exp_bytes.delete();
        @(negedge clk);
        chk("mid_rst_send", tx_send_o, 0);
        chk("mid_rst_data", tx_data_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ovf", overflow_o, 0);
        chk("mid_rst_level", fifo_level_o, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        ns = 0;
        repeat (80) begin
            @(negedge clk);
            if (tx_send_o) ns++;
        end
        chk("post_rst_no_send", ns, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_level", fifo_level_o, 0);

        push_one(16'hC3C3, 1'b1);
        wait_drain("drain_recover", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
